fp_arbiter: RTL
===============

FP_ARBITER -- requirements
Module: fp_arbiter

Interface
REQ-001 Parameter NREQ, default 2, is the number of requesters sharing one fp_unit; supported values are 2..4.
REQ-002 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port req_valid, input, NREQ bits: per-requester operation request.
REQ-005 Port req_data, input, NREQ x fp_exe_in_type: per-requester operands, fmt, rm and op; the enable field is ignored.
REQ-006 Port req_ready, output, NREQ bits: one-hot acceptance strobe; a request is taken when req_valid[i] and req_ready[i] are both 1.
REQ-007 Port rsp_valid, output, NREQ bits: one-hot completion strobe to the owning requester.
REQ-008 Port rsp_result, output, 64 bits: result, meaningful only while any rsp_valid bit is 1.
REQ-009 Port rsp_flags, output, 5 bits: NV,DZ,OF,UF,NX flags, qualified the same way as rsp_result.
REQ-010 Port fp_exe_i, output, fp_exe_in_type: drive to fp_unit.
REQ-011 Port fp_exe_o, input, fp_exe_out_type: result, flags and ready from fp_unit.
REQ-012 Port busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-013 FSM states are IDLE, ISSUE and WAIT; at most one operation is outstanding at any time.
REQ-014 IDLE with no req_valid: the FSM stays in IDLE, and req_ready and fp_exe_i.enable are 0.
REQ-015 IDLE with any req_valid bit set: the grant g is the first set bit searching upward from ptr, wrapping modulo NREQ; req_ready[g] is 1 combinationally in that cycle; req_data[g] and owner=g are latched; the next state is ISSUE.
REQ-016 ISSUE: fp_exe_i carries the latched payload with enable=1 for exactly one cycle; the next state is WAIT.
REQ-017 WAIT: fp_exe_i holds the latched payload with enable=0 until fp_exe_o.ready=1.
REQ-018 WAIT with fp_exe_o.ready=1: in the same cycle rsp_valid[owner]=1, rsp_result=fp_exe_o.result and rsp_flags=fp_exe_o.flags (combinational pass-through); on the next edge ptr becomes (owner+1) mod NREQ and the state becomes IDLE.
REQ-019 fp_exe_o.ready is ignored in IDLE and ISSUE.
REQ-020 Throughput: at most one operation is accepted per 3 cycles; latency from acceptance to rsp_valid is fp_unit latency + 1 cycle.
REQ-021 req_valid changes during ISSUE or WAIT have no effect; a requester may drop req_valid before it is accepted with no side effects.
REQ-022 Simultaneous requests are served in strict round-robin: with all NREQ requesting continuously, each requester is granted once per NREQ grants.
REQ-023 When rsp_valid is 0, rsp_result and rsp_flags are 0.

Reset
REQ-024 On reset assertion, state, ptr and owner reset to IDLE/0/0 and the latched payload clears to zero, asynchronously and independent of clock.
REQ-025 While reset is high, req_ready, rsp_valid, fp_exe_i.enable and busy are 0.
REQ-026 An operation in flight at reset is abandoned: no rsp_valid is produced for it, and an fp_exe_o.ready arriving after reset while in IDLE is ignored.

Structure
REQ-027 The fp_arb_state_type enumeration (IDLE, ISSUE, WAIT) is declared in package fp_wire, next to fp_exe_in_type and fp_exe_out_type.
REQ-028 The round-robin picker is the sub-module fp_rr_pick; it is purely combinational, with inputs req and ptr and outputs grant_onehot and grant_index.
REQ-029 fp_arbiter instantiates no fp_unit; the bench connects an fp_unit to fp_exe_i and fp_exe_o.

Verification
REQ-030 Requester 0 single fadd, 0x3F800000 + 0x40000000, rm=0: rsp_valid[0] with result 0x40400000, flags 0x00; busy falls the cycle after.
REQ-031 Both requesters assert in the first cycle after reset: requester 0 is accepted first, requester 1 on the next IDLE, and each receives only its own rsp_valid.
REQ-032 Requester 1 single fdiv, 0x3F800000 / 0x00000000: result 0x7F800000, flags 0x08 (DZ).
REQ-033 Requester 0 single fsqrt of 0xBF800000 issued while requester 1 is pending: requester 0 gets result 0x7FC00000, flags 0x10; requester 1 is served next.
REQ-034 Reset pulsed during WAIT of a long fdiv: outputs go 0 immediately, no rsp_valid is emitted, and the next request is granted starting from requester 0.
REQ-035 Four requesters (NREQ=4) all continuously valid for 12 operations: the grant order is 0,1,2,3 repeated, and the bench checks it.

Source files
------------

// File: rtl/fp_wire_pkg.sv
// Shared types for the fp_unit wiring: operation codes, the execute-stage
// request/response records and the arbiter state encoding.
package fp_wire;

  // Operation selector carried to the fp_unit.
  typedef enum logic [3:0] {
    FP_FADD  = 4'd0,
    FP_FSUB  = 4'd1,
    FP_FMUL  = 4'd2,
    FP_FDIV  = 4'd3,
    FP_FSQRT = 4'd4,
    FP_FMIN  = 4'd5,
    FP_FMAX  = 4'd6,
    FP_FCVT  = 4'd7
  } fp_op_type;

  // Exception flag positions within the 5-bit flag vector.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Request toward the fp_unit; enable is a one-cycle start strobe.
  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] data3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    fp_op_type   op;
    logic        enable;
  } fp_exe_in_type;

  // Completion from the fp_unit; ready marks the cycle result/flags are valid.
  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  // Arbiter sequencing: accept, strobe the unit, then wait for completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fp_arb_state_type;

endpackage

// File: rtl/fp_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ.
module fp_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IW-1:0]   grant_index
);

  // cand[k] is the requester index visited k steps after ptr.
  logic [IW-1:0] cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum      = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest one to ptr wins.
  always_comb begin
    grant_index  = '0;
    grant_onehot = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant_index = cand[k];
      end
    end
    if (|req) begin
      grant_onehot[grant_index] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_arbiter.sv
// Shares one fp_unit among NREQ requesters with one operation in flight,
// round-robin grants and a combinational response pass-through.
module fp_arbiter
  import fp_wire::*;
#(
  parameter int NREQ = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NREQ-1:0] req_valid,
  input  fp_exe_in_type  req_data [NREQ],
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] rsp_valid,
  output logic [63:0]    rsp_result,
  output logic [4:0]     rsp_flags,
  output fp_exe_in_type  fp_exe_i,
  input  fp_exe_out_type fp_exe_o,
  output logic           busy
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  fp_arb_state_type state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  fp_exe_in_type    payload;

  logic [NREQ-1:0]  grant_onehot;
  logic [IW-1:0]    grant_index;
  fp_exe_in_type    picked;
  logic [IW-1:0]    ptr_after;
  logic             any_req;
  logic             done;

  assign any_req = |req_valid;
  // Completion only counts while actually waiting; stray ready is dropped.
  assign done    = (state == WAIT) && fp_exe_o.ready;

  fp_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req          (req_valid),
    .ptr          (ptr),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index)
  );

  // Select the granted payload; the requester's enable bit is never trusted.
  always_comb begin
    picked        = req_data[grant_index];
    picked.enable = 1'b0;
  end

  assign ptr_after = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

  // FSM, round-robin pointer, owner and latched operands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      payload <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            payload <= picked;
            owner   <= grant_index;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (fp_exe_o.ready) begin
            ptr   <= ptr_after;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Drive the unit from the latched payload; start strobe only in ISSUE.
  always_comb begin
    fp_exe_i        = payload;
    fp_exe_i.enable = (state == ISSUE);
  end

  // Acceptance is combinational in IDLE and held off while reset is high.
  assign req_ready = ((state == IDLE) && !reset) ? grant_onehot : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = done && (owner == IW'(gi));
    end
  endgenerate

  assign rsp_result = done ? fp_exe_o.result : '0;
  assign rsp_flags  = done ? fp_exe_o.flags  : '0;
  assign busy       = (state != IDLE);

endmodule
